// File: rtl/pzcorebus_write_request_scheduler_pkg.sv
// Shared types for the write request scheduler: order FIFO entry, arbiter
// lock states and the round-robin pointer helper.
package pzcorebus_write_request_scheduler_pkg;

    // Field widths sized for the largest supported configuration
    // (16 requesters, bursts up to 255 beats).
    localparam int unsigned MAX_SRC_W = 4;
    localparam int unsigned MAX_BL_W  = 8;

    typedef logic [MAX_SRC_W-1:0] pz_src_t;
    typedef logic [MAX_BL_W-1:0]  pz_bl_t;

    // One granted write awaiting its data: who owns it and how many beats.
    typedef struct packed {
        pz_src_t src;
        pz_bl_t  burst_length;
    } pzcorebus_write_order_entry;

    // Command grant is either free to re-arbitrate or locked on a grantee.
    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Requester index following idx, wrapping at n.
    function automatic pz_src_t rr_next_index(input pz_src_t idx, input int unsigned n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + pz_src_t'(1);
    endfunction

endpackage

// File: rtl/pzcorebus_write_request_scheduler_if.sv
// Bus bundle between N requesters, the scheduler and the downstream corebus
// port. Names follow the scheduler's point of view (i_* into it, o_* out).
//   master : the scheduler itself (drives the shared downstream port)
//   slave  : the surrounding requesters and downstream slave
interface pzcorebus_write_request_scheduler_if #(
    parameter int unsigned N      = 2,
    parameter int unsigned CMD_W  = 64,
    parameter int unsigned DATA_W = 160,
    parameter int unsigned BL_W   = 5,
    parameter int unsigned SRC_W  = 1
);
    // Requester command channel
    logic [N-1:0]        i_mcmd_valid;
    logic [N-1:0]        o_scmd_accept;
    logic [N-1:0]        i_mcmd_write;
    logic [N*BL_W-1:0]   i_mburst_length;
    logic [N*CMD_W-1:0]  i_mcmd_payload;
    // Downstream command channel
    logic                o_mcmd_valid;
    logic                i_scmd_accept;
    logic                o_mcmd_write;
    logic [BL_W-1:0]     o_mburst_length;
    logic [CMD_W-1:0]    o_mcmd_payload;
    logic [SRC_W-1:0]    o_mcmd_source;
    // Requester write-data channel
    logic [N-1:0]        i_mdata_valid;
    logic [N-1:0]        o_sdata_accept;
    logic [N-1:0]        i_mdata_last;
    logic [N*DATA_W-1:0] i_mdata_payload;
    // Downstream write-data channel
    logic                o_mdata_valid;
    logic                i_sdata_accept;
    logic                o_mdata_last;
    logic [DATA_W-1:0]   o_mdata_payload;
    // Status
    logic                o_burst_error;
    logic                o_busy;

    modport master (
        input  i_mcmd_valid, i_mcmd_write, i_mburst_length, i_mcmd_payload,
        output o_scmd_accept,
        output o_mcmd_valid, o_mcmd_write, o_mburst_length, o_mcmd_payload, o_mcmd_source,
        input  i_scmd_accept,
        input  i_mdata_valid, i_mdata_last, i_mdata_payload,
        output o_sdata_accept,
        output o_mdata_valid, o_mdata_last, o_mdata_payload,
        input  i_sdata_accept,
        output o_burst_error, o_busy
    );

    modport slave (
        output i_mcmd_valid, i_mcmd_write, i_mburst_length, i_mcmd_payload,
        input  o_scmd_accept,
        input  o_mcmd_valid, o_mcmd_write, o_mburst_length, o_mcmd_payload, o_mcmd_source,
        output i_scmd_accept,
        output i_mdata_valid, i_mdata_last, i_mdata_payload,
        input  o_sdata_accept,
        input  o_mdata_valid, o_mdata_last, o_mdata_payload,
        output i_sdata_accept,
        input  o_burst_error, o_busy
    );

endinterface

// File: rtl/pzcorebus_write_order_fifo.sv
// Synchronous FIFO of granted-write order entries with registered full/empty.
// Ports: i_clk, i_rst (sync, active high), i_push/i_data, i_pop,
//        o_data (head entry), o_full, o_empty.
// A push while full is taken only when a pop happens in the same cycle.
module pzcorebus_write_order_fifo
    import pzcorebus_write_request_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  pzcorebus_write_order_entry i_data,
    input  logic                       i_pop,
    output pzcorebus_write_order_entry o_data,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    pzcorebus_write_order_entry mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // Pop is resolved first so a full FIFO can accept a push alongside it.
    always_comb begin
        do_pop  = i_pop && !empty_q;
        do_push = i_push && (!full_q || do_pop);
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    // Storage needs no reset; occupancy flags gate every read.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr_q] <= i_data;
    end

    assign o_data  = mem[rd_ptr_q];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/pzcorebus_write_request_scheduler.sv
// Shares one corebus command + write-data port between N requesters.
// Commands: round-robin, zero-latency mux, grant held until downstream accept.
// Write data: forwarded strictly in granted-command order from an order FIFO,
// with the downstream last flag computed from the burst length and a one-cycle
// o_burst_error pulse when the requester's own last flag disagrees.
// Ports: i_clk, i_rst (sync, active high), bus (master modport of
//        pzcorebus_write_request_scheduler_if carrying all channel signals).
module pzcorebus_write_request_scheduler
    import pzcorebus_write_request_scheduler_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned CMD_W      = 64,
    parameter int unsigned DATA_W     = 160,
    parameter int unsigned MAX_BURST  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    pzcorebus_write_request_scheduler_if.master bus
);
    localparam int unsigned BL_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned SRC_W = (N > 1) ? $clog2(N) : 1;

    arb_state_e state_q, state_d;
    pz_src_t    lock_src_q, lock_src_d;
    pz_src_t    ptr_q;
    pz_src_t    grant;
    logic [N-1:0] elig, hi_mask, cand, gnt_oh;
    logic         found;

    logic              cmd_valid, cmd_write, cmd_ack;
    logic [BL_W-1:0]   raw_bl, norm_bl;
    logic [CMD_W-1:0]  cmd_payload;

    pzcorebus_write_order_entry fifo_head, push_entry;
    logic fifo_full, fifo_empty, fifo_push;

    logic [N-1:0]      head_oh;
    logic              data_valid, data_last, req_last, data_ack, last_ack;
    logic [DATA_W-1:0] data_payload;
    logic [BL_W-1:0]   beat_q;
    logic              err_q;

    // Grant select: locked grantee, else first eligible at/after the pointer.
    always_comb begin
        elig    = '0;
        hi_mask = '0;
        gnt_oh  = '0;
        grant   = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            elig[i]    = bus.i_mcmd_valid[i] && !(bus.i_mcmd_write[i] && fifo_full);
            hi_mask[i] = (32'(i) >= 32'(ptr_q));
        end
        cand = (|(elig & hi_mask)) ? (elig & hi_mask) : elig;
        if (state_q == ARB_LOCKED) begin
            for (int i = 0; i < N; i++) begin
                if (pz_src_t'(i) == lock_src_q) begin
                    gnt_oh[i] = 1'b1;
                    grant     = pz_src_t'(i);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!found && cand[i]) begin
                    found     = 1'b1;
                    gnt_oh[i] = 1'b1;
                    grant     = pz_src_t'(i);
                end
            end
        end
    end

    // Command mux; out-of-range burst lengths collapse to MAX_BURST.
    always_comb begin
        cmd_valid   = |(gnt_oh & bus.i_mcmd_valid);
        cmd_write   = 1'b0;
        raw_bl      = '0;
        cmd_payload = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_oh[i]) begin
                cmd_write   = bus.i_mcmd_write[i];
                raw_bl      = bus.i_mburst_length[i*BL_W +: BL_W];
                cmd_payload = bus.i_mcmd_payload[i*CMD_W +: CMD_W];
            end
        end
        norm_bl = ((raw_bl == '0) || (32'(raw_bl) > MAX_BURST)) ? BL_W'(MAX_BURST) : raw_bl;
        cmd_ack = cmd_valid && bus.i_scmd_accept;
        fifo_push = cmd_ack && cmd_write;
        push_entry.src          = grant;
        push_entry.burst_length = pz_bl_t'(norm_bl);
    end

    // Lock FSM: hold the grantee while downstream stalls a valid command.
    always_comb begin
        state_d    = state_q;
        lock_src_d = lock_src_q;
        case (state_q)
            ARB_OPEN: begin
                if (cmd_valid && !bus.i_scmd_accept) begin
                    state_d    = ARB_LOCKED;
                    lock_src_d = grant;
                end
            end
            ARB_LOCKED: begin
                if (bus.i_scmd_accept || !cmd_valid) state_d = ARB_OPEN;
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    pzcorebus_write_order_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_order_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (fifo_push),
        .i_data  (push_entry),
        .i_pop   (last_ack),
        .o_data  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // Data path: only the FIFO head's requester is ever accepted.
    always_comb begin
        head_oh = '0;
        for (int i = 0; i < N; i++) begin
            head_oh[i] = !fifo_empty && (pz_src_t'(i) == fifo_head.src);
        end
        data_valid   = |(head_oh & bus.i_mdata_valid);
        req_last     = |(head_oh & bus.i_mdata_last);
        data_payload = '0;
        for (int i = 0; i < N; i++) begin
            if (head_oh[i]) data_payload = bus.i_mdata_payload[i*DATA_W +: DATA_W];
        end
        data_last = !fifo_empty &&
                    ((pz_bl_t'(beat_q) + pz_bl_t'(1)) == fifo_head.burst_length);
        data_ack  = data_valid && bus.i_sdata_accept;
        last_ack  = data_ack && data_last;
    end

    // Arbiter state, RR pointer, beat counter and error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ARB_OPEN;
            lock_src_q <= '0;
            ptr_q      <= '0;
            beat_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_src_q <= lock_src_d;
            if (cmd_ack) ptr_q <= rr_next_index(grant, N);
            if (last_ack) begin
                beat_q <= '0;
            end else if (data_ack) begin
                beat_q <= beat_q + BL_W'(1);
            end
            err_q <= data_ack && (req_last != data_last);
        end
    end

    assign bus.o_mcmd_valid    = cmd_valid;
    assign bus.o_scmd_accept   = gnt_oh & bus.i_mcmd_valid & {N{bus.i_scmd_accept}};
    assign bus.o_mcmd_write    = cmd_write;
    assign bus.o_mburst_length = norm_bl;
    assign bus.o_mcmd_payload  = cmd_payload;
    assign bus.o_mcmd_source   = SRC_W'(grant);
    assign bus.o_mdata_valid   = data_valid;
    assign bus.o_sdata_accept  = head_oh & {N{bus.i_sdata_accept}};
    assign bus.o_mdata_last    = data_last;
    assign bus.o_mdata_payload = data_payload;
    assign bus.o_burst_error   = err_q;
    assign bus.o_busy          = !fifo_empty || (|bus.i_mcmd_valid);

endmodule

// File: tb/tb_pzcorebus_write_request_scheduler.sv
// Directed bench for the write request scheduler (N=2, depth-4 order FIFO).
module tb_pzcorebus_write_request_scheduler;
    localparam int unsigned N = 2, CMD_W = 64, DATA_W = 160, MAX_BURST = 16, FIFO_DEPTH = 4;
    localparam int unsigned BL_W = 5, SRC_W = 1;

    logic clk;
    logic rst;
    int   cmp_cnt = 0;
    int   mis_cnt = 0;

    pzcorebus_write_request_scheduler_if #(
        .N(N), .CMD_W(CMD_W), .DATA_W(DATA_W), .BL_W(BL_W), .SRC_W(SRC_W)
    ) bif ();

    pzcorebus_write_request_scheduler #(
        .N(N), .CMD_W(CMD_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #3;
    endtask

    task automatic idle_inputs;
        bif.i_mcmd_valid    = '0;
        bif.i_mcmd_write    = '0;
        bif.i_mburst_length = '0;
        bif.i_mcmd_payload  = '0;
        bif.i_scmd_accept   = 1'b0;
        bif.i_mdata_valid   = '0;
        bif.i_mdata_last    = '0;
        bif.i_mdata_payload = '0;
        bif.i_sdata_accept  = 1'b0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        settle();
        cmp_cnt++; if (bif.o_mcmd_valid !== 1'b0) begin mis_cnt++; $display("FAIL reset_mcmd_valid got %0h want 0", bif.o_mcmd_valid); end
        cmp_cnt++; if (bif.o_mdata_valid !== 1'b0) begin mis_cnt++; $display("FAIL reset_mdata_valid got %0h want 0", bif.o_mdata_valid); end
        cmp_cnt++; if (bif.o_scmd_accept !== 2'b00) begin mis_cnt++; $display("FAIL reset_scmd_accept got %0h want 0", bif.o_scmd_accept); end
        cmp_cnt++; if (bif.o_sdata_accept !== 2'b00) begin mis_cnt++; $display("FAIL reset_sdata_accept got %0h want 0", bif.o_sdata_accept); end
        cmp_cnt++; if (bif.o_burst_error !== 1'b0) begin mis_cnt++; $display("FAIL reset_burst_error got %0h want 0", bif.o_burst_error); end
        cmp_cnt++; if (bif.o_busy !== 1'b0) begin mis_cnt++; $display("FAIL reset_busy got %0h want 0", bif.o_busy); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write;
        logic [DATA_W-1:0] exp_d;
        do_reset();
        bif.i_mcmd_valid    = 2'b01;
        bif.i_mcmd_write    = 2'b01;
        bif.i_mburst_length = {5'd0, 5'd4};
        bif.i_mcmd_payload  = {64'h0, 64'hC0DE_0000_0000_0004};
        bif.i_scmd_accept   = 1'b1;
        bif.i_mdata_valid   = 2'b01;
        bif.i_sdata_accept  = 1'b1;
        bif.i_mdata_payload = {160'h0, 160'hD000};
        settle();
        cmp_cnt++; if (bif.o_mcmd_valid !== 1'b1) begin mis_cnt++; $display("FAIL single_cmd_valid got %0h want 1", bif.o_mcmd_valid); end
        cmp_cnt++; if (bif.o_scmd_accept !== 2'b01) begin mis_cnt++; $display("FAIL single_scmd_accept got %0h want 1", bif.o_scmd_accept); end
        cmp_cnt++; if (bif.o_mcmd_source !== 1'b0) begin mis_cnt++; $display("FAIL single_source got %0h want 0", bif.o_mcmd_source); end
        cmp_cnt++; if (bif.o_mburst_length !== 5'd4) begin mis_cnt++; $display("FAIL single_burst_len got %0d want 4", bif.o_mburst_length); end
        cmp_cnt++; if (bif.o_mcmd_payload !== 64'hC0DE_0000_0000_0004) begin mis_cnt++; $display("FAIL single_cmd_payload got %0h want c0de000000000004", bif.o_mcmd_payload); end
        cmp_cnt++; if (bif.o_mdata_valid !== 1'b0) begin mis_cnt++; $display("FAIL single_data_before_push got %0h want 0", bif.o_mdata_valid); end
        tick();
        bif.i_mcmd_valid = 2'b00;
        for (int b = 1; b <= 4; b++) begin
            exp_d = DATA_W'(32'hD000 + b);
            bif.i_mdata_payload = {160'h0, exp_d};
            bif.i_mdata_last    = (b == 4) ? 2'b01 : 2'b00;
            settle();
            cmp_cnt++; if (bif.o_mdata_valid !== 1'b1) begin mis_cnt++; $display("FAIL single_data_valid beat %0d got %0h want 1", b, bif.o_mdata_valid); end
            cmp_cnt++; if (bif.o_sdata_accept !== 2'b01) begin mis_cnt++; $display("FAIL single_sdata_accept beat %0d got %0h want 1", b, bif.o_sdata_accept); end
            cmp_cnt++; if (bif.o_mdata_last !== (b == 4)) begin mis_cnt++; $display("FAIL single_last beat %0d got %0h want %0h", b, bif.o_mdata_last, (b == 4)); end
            cmp_cnt++; if (bif.o_mdata_payload !== exp_d) begin mis_cnt++; $display("FAIL single_payload beat %0d got %0h want %0h", b, bif.o_mdata_payload, exp_d); end
            tick();
        end
        settle();
        cmp_cnt++; if (bif.o_mdata_valid !== 1'b0) begin mis_cnt++; $display("FAIL single_after_pop_valid got %0h want 0", bif.o_mdata_valid); end
        cmp_cnt++; if (bif.o_busy !== 1'b0) begin mis_cnt++; $display("FAIL single_after_pop_busy got %0h want 0", bif.o_busy); end
        cmp_cnt++; if (bif.o_burst_error !== 1'b0) begin mis_cnt++; $display("FAIL single_no_error got %0h want 0", bif.o_burst_error); end
    endtask

    task automatic test_rr_reads;
        do_reset();
        bif.i_mcmd_valid  = 2'b11;
        bif.i_mcmd_write  = 2'b00;
        bif.i_scmd_accept = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            cmp_cnt++; if (bif.o_mcmd_source !== 1'(k % 2)) begin mis_cnt++; $display("FAIL rr_source cycle %0d got %0h want %0h", k, bif.o_mcmd_source, k % 2); end
            cmp_cnt++; if (bif.o_scmd_accept !== ((k % 2) ? 2'b10 : 2'b01)) begin mis_cnt++; $display("FAIL rr_accept cycle %0d got %0h", k, bif.o_scmd_accept); end
            tick();
        end
    endtask

    task automatic test_data_order;
        logic [DATA_W-1:0] d0;
        logic [DATA_W-1:0] d1;
        d0 = 160'hAAAA_0000;
        d1 = 160'hBBBB_1111;
        do_reset();
        bif.i_mdata_payload = {d1, d0};
        bif.i_sdata_accept  = 1'b1;
        bif.i_mdata_valid   = 2'b01;
        bif.i_scmd_accept   = 1'b1;
        bif.i_mburst_length = {5'd2, 5'd3};
        bif.i_mcmd_valid    = 2'b10;
        bif.i_mcmd_write    = 2'b10;
        settle();
        cmp_cnt++; if (bif.o_mcmd_source !== 1'b1) begin mis_cnt++; $display("FAIL order_first_grant got %0h want 1", bif.o_mcmd_source); end
        cmp_cnt++; if (bif.o_sdata_accept !== 2'b00) begin mis_cnt++; $display("FAIL order_empty_accept got %0h want 0", bif.o_sdata_accept); end
        tick();
        bif.i_mcmd_valid = 2'b01;
        bif.i_mcmd_write = 2'b01;
        settle();
        cmp_cnt++; if (bif.o_scmd_accept !== 2'b01) begin mis_cnt++; $display("FAIL order_second_grant got %0h want 1", bif.o_scmd_accept); end
        cmp_cnt++; if (bif.o_sdata_accept !== 2'b10) begin mis_cnt++; $display("FAIL order_holdoff_r0 got %0h want 2", bif.o_sdata_accept); end
        cmp_cnt++; if (bif.o_mdata_valid !== 1'b0) begin mis_cnt++; $display("FAIL order_head_not_ready got %0h want 0", bif.o_mdata_valid); end
        tick();
        bif.i_mcmd_valid  = 2'b00;
        bif.i_mdata_valid = 2'b11;
        for (int b = 1; b <= 2; b++) begin
            bif.i_mdata_last = (b == 2) ? 2'b10 : 2'b00;
            settle();
            cmp_cnt++; if (bif.o_sdata_accept !== 2'b10) begin mis_cnt++; $display("FAIL order_r1_accept beat %0d got %0h want 2", b, bif.o_sdata_accept); end
            cmp_cnt++; if (bif.o_mdata_last !== (b == 2)) begin mis_cnt++; $display("FAIL order_r1_last beat %0d got %0h", b, bif.o_mdata_last); end
            cmp_cnt++; if (bif.o_mdata_payload !== d1) begin mis_cnt++; $display("FAIL order_r1_payload beat %0d got %0h", b, bif.o_mdata_payload); end
            tick();
        end
        bif.i_mdata_valid = 2'b01;
        for (int b = 1; b <= 3; b++) begin
            bif.i_mdata_last = (b == 3) ? 2'b01 : 2'b00;
            settle();
            cmp_cnt++; if (bif.o_sdata_accept !== 2'b01) begin mis_cnt++; $display("FAIL order_r0_accept beat %0d got %0h want 1", b, bif.o_sdata_accept); end
            cmp_cnt++; if (bif.o_mdata_last !== (b == 3)) begin mis_cnt++; $display("FAIL order_r0_last beat %0d got %0h", b, bif.o_mdata_last); end
            cmp_cnt++; if (bif.o_mdata_payload !== d0) begin mis_cnt++; $display("FAIL order_r0_payload beat %0d got %0h", b, bif.o_mdata_payload); end
            tick();
        end
        settle();
        cmp_cnt++; if (bif.o_mdata_valid !== 1'b0) begin mis_cnt++; $display("FAIL order_drained got %0h want 0", bif.o_mdata_valid); end
        cmp_cnt++; if (bif.o_burst_error !== 1'b0) begin mis_cnt++; $display("FAIL order_no_error got %0h want 0", bif.o_burst_error); end
    endtask

    task automatic test_hold;
        do_reset();
        bif.i_mcmd_valid  = 2'b01;
        bif.i_scmd_accept = 1'b1;
        tick();
        bif.i_mcmd_write    = 2'b01;
        bif.i_mburst_length = {5'd1, 5'd5};
        bif.i_mcmd_payload  = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        bif.i_scmd_accept   = 1'b0;
        for (int h = 0; h < 3; h++) begin
            if (h == 1) bif.i_mcmd_valid = 2'b11;
            settle();
            cmp_cnt++; if (bif.o_mcmd_source !== 1'b0) begin mis_cnt++; $display("FAIL hold_source cycle %0d got %0h want 0", h, bif.o_mcmd_source); end
            cmp_cnt++; if (bif.o_mcmd_payload !== 64'h5555_6666_7777_8888) begin mis_cnt++; $display("FAIL hold_payload cycle %0d got %0h", h, bif.o_mcmd_payload); end
            cmp_cnt++; if (bif.o_mcmd_write !== 1'b1) begin mis_cnt++; $display("FAIL hold_write cycle %0d got %0h want 1", h, bif.o_mcmd_write); end
            cmp_cnt++; if (bif.o_scmd_accept !== 2'b00) begin mis_cnt++; $display("FAIL hold_accept cycle %0d got %0h want 0", h, bif.o_scmd_accept); end
            tick();
        end
        bif.i_scmd_accept = 1'b1;
        settle();
        cmp_cnt++; if (bif.o_scmd_accept !== 2'b01) begin mis_cnt++; $display("FAIL hold_release_accept got %0h want 1", bif.o_scmd_accept); end
        tick();
        bif.i_mcmd_valid = 2'b10;
        settle();
        cmp_cnt++; if (bif.o_mcmd_source !== 1'b1) begin mis_cnt++; $display("FAIL hold_next_source got %0h want 1", bif.o_mcmd_source); end
        cmp_cnt++; if (bif.o_mcmd_payload !== 64'h1111_2222_3333_4444) begin mis_cnt++; $display("FAIL hold_next_payload got %0h", bif.o_mcmd_payload); end
    endtask

    task automatic test_fifo_full;
        do_reset();
        bif.i_scmd_accept   = 1'b1;
        bif.i_sdata_accept  = 1'b1;
        bif.i_mburst_length = {5'd1, 5'd1};
        bif.i_mcmd_valid    = 2'b01;
        bif.i_mcmd_write    = 2'b01;
        for (int k = 0; k < 4; k++) begin
            settle();
            cmp_cnt++; if (bif.o_scmd_accept !== 2'b01) begin mis_cnt++; $display("FAIL full_fill write %0d got %0h want 1", k, bif.o_scmd_accept); end
            tick();
        end
        bif.i_mcmd_valid = 2'b11;
        settle();
        cmp_cnt++; if (bif.o_mcmd_source !== 1'b1) begin mis_cnt++; $display("FAIL full_read_wins got %0h want 1", bif.o_mcmd_source); end
        cmp_cnt++; if (bif.o_scmd_accept !== 2'b10) begin mis_cnt++; $display("FAIL full_read_accept got %0h want 2", bif.o_scmd_accept); end
        tick();
        bif.i_mcmd_valid  = 2'b01;
        bif.i_mdata_valid = 2'b01;
        bif.i_mdata_last  = 2'b01;
        settle();
        cmp_cnt++; if (bif.o_mcmd_valid !== 1'b0) begin mis_cnt++; $display("FAIL full_write_blocked got %0h want 0", bif.o_mcmd_valid); end
        cmp_cnt++; if (bif.o_mdata_last !== 1'b1) begin mis_cnt++; $display("FAIL full_pop_last got %0h want 1", bif.o_mdata_last); end
        tick();
        bif.i_mdata_valid = 2'b00;
        settle();
        cmp_cnt++; if (bif.o_mcmd_valid !== 1'b1) begin mis_cnt++; $display("FAIL full_write_after_pop got %0h want 1", bif.o_mcmd_valid); end
        cmp_cnt++; if (bif.o_scmd_accept !== 2'b01) begin mis_cnt++; $display("FAIL full_write_accept got %0h want 1", bif.o_scmd_accept); end
        tick();
    endtask

    task automatic test_burst_error;
        do_reset();
        bif.i_mcmd_valid    = 2'b01;
        bif.i_mcmd_write    = 2'b01;
        bif.i_mburst_length = {5'd0, 5'd3};
        bif.i_scmd_accept   = 1'b1;
        bif.i_sdata_accept  = 1'b1;
        tick();
        bif.i_mcmd_valid  = 2'b00;
        bif.i_mdata_valid = 2'b01;
        settle();
        cmp_cnt++; if (bif.o_mdata_last !== 1'b0) begin mis_cnt++; $display("FAIL err_beat1_last got %0h want 0", bif.o_mdata_last); end
        tick();
        bif.i_mdata_last = 2'b01;
        settle();
        cmp_cnt++; if (bif.o_mdata_last !== 1'b0) begin mis_cnt++; $display("FAIL err_beat2_last got %0h want 0", bif.o_mdata_last); end
        cmp_cnt++; if (bif.o_burst_error !== 1'b0) begin mis_cnt++; $display("FAIL err_before_pulse got %0h want 0", bif.o_burst_error); end
        tick();
        bif.i_mdata_last   = 2'b00;
        bif.i_sdata_accept = 1'b0;
        settle();
        cmp_cnt++; if (bif.o_burst_error !== 1'b1) begin mis_cnt++; $display("FAIL err_pulse got %0h want 1", bif.o_burst_error); end
        cmp_cnt++; if (bif.o_mdata_last !== 1'b1) begin mis_cnt++; $display("FAIL err_beat3_last got %0h want 1", bif.o_mdata_last); end
        tick();
        bif.i_sdata_accept = 1'b1;
        rst = 1'b1;
        settle();
        cmp_cnt++; if (bif.o_burst_error !== 1'b0) begin mis_cnt++; $display("FAIL err_pulse_one_cycle got %0h want 0", bif.o_burst_error); end
        tick();
        rst = 1'b0;
        settle();
        cmp_cnt++; if (bif.o_mdata_valid !== 1'b0) begin mis_cnt++; $display("FAIL err_rst_mdata_valid got %0h want 0", bif.o_mdata_valid); end
        cmp_cnt++; if (bif.o_sdata_accept !== 2'b00) begin mis_cnt++; $display("FAIL err_rst_sdata_accept got %0h want 0", bif.o_sdata_accept); end
        cmp_cnt++; if (bif.o_burst_error !== 1'b0) begin mis_cnt++; $display("FAIL err_rst_burst_error got %0h want 0", bif.o_burst_error); end
        cmp_cnt++; if (bif.o_busy !== 1'b0) begin mis_cnt++; $display("FAIL err_rst_busy got %0h want 0", bif.o_busy); end
        cmp_cnt++; if (bif.o_mcmd_valid !== 1'b0) begin mis_cnt++; $display("FAIL err_rst_mcmd_valid got %0h want 0", bif.o_mcmd_valid); end
    endtask

    task automatic test_length_clamp;
        do_reset();
        bif.i_mcmd_valid    = 2'b10;
        bif.i_mcmd_write    = 2'b10;
        bif.i_mburst_length = {5'd0, 5'd0};
        bif.i_scmd_accept   = 1'b1;
        bif.i_sdata_accept  = 1'b1;
        settle();
        cmp_cnt++; if (bif.o_mburst_length !== 5'd16) begin mis_cnt++; $display("FAIL clamp_burst_len got %0d want 16", bif.o_mburst_length); end
        tick();
        bif.i_mcmd_valid  = 2'b00;
        bif.i_mdata_valid = 2'b10;
        for (int b = 1; b <= 16; b++) begin
            bif.i_mdata_last = (b == 16) ? 2'b10 : 2'b00;
            settle();
            cmp_cnt++; if (bif.o_mdata_last !== (b == 16)) begin mis_cnt++; $display("FAIL clamp_last beat %0d got %0h want %0h", b, bif.o_mdata_last, (b == 16)); end
            tick();
        end
        settle();
        cmp_cnt++; if (bif.o_mdata_valid !== 1'b0) begin mis_cnt++; $display("FAIL clamp_drained got %0h want 0", bif.o_mdata_valid); end
        cmp_cnt++; if (bif.o_burst_error !== 1'b0) begin mis_cnt++; $display("FAIL clamp_no_error got %0h want 0", bif.o_burst_error); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_write();
        test_rr_reads();
        test_data_order();
        test_hold();
        test_fifo_full();
        test_burst_error();
        test_length_clamp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
